// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: access sizes,
// controller states and the default I/O window selector.
package mem_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] IO_SEL_DEF = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  // Size code 3 is illegal and is serviced as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store requests and
// moves 1/2/4-byte little-endian accesses over the 8-bit RAM/UART bus.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter logic [1:0]  IO_SEL = IO_SEL_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;
  logic [31:0]       merged;
  logic [2:0]        n_q;
  logic [2:0]        idx_q;
  logic [2:0]        idx_nxt;
  logic [2:0]        first_idx;
  logic              vld_q;
  logic              stale_q;
  logic              fetch_q;
  logic              accept;
  logic              io_hit;
  logic              wr_fire;
  logic              last_wr;
  logic              cap_last;
  logic [7:0]        nxt_byte;

  // idx_q is the byte index currently on mem_a; vld_q marks that mem_din
  // holds byte idx_q-1 this cycle.
  assign io_hit    = (mem_a[17:16] == IO_SEL);
  assign wr_fire   = (state_q == WRITE) && rdy_in && !(io_hit && io_buffer_full);
  assign mem_wr    = wr_fire;
  assign accept    = (state_q == IDLE) && rdy_in && !flush && !if_done && !ls_done
                     && (ls_req || if_req);
  assign idx_nxt   = idx_q + 3'd1;
  assign first_idx = idx_q - {2'b00, vld_q};
  assign last_wr   = (idx_q == n_q - 3'd1);
  assign cap_last  = vld_q && (idx_q == n_q);

  always_comb begin
    merged = asm_q;
    case (idx_q)
      3'd1:    merged[7:0]   = mem_din;
      3'd2:    merged[15:8]  = mem_din;
      3'd3:    merged[23:16] = mem_din;
      3'd4:    merged[31:24] = mem_din;
      default: merged = asm_q;
    endcase
  end

  always_comb begin
    case (idx_nxt[1:0])
      2'd0:    nxt_byte = wdata_q[7:0];
      2'd1:    nxt_byte = wdata_q[15:8];
      2'd2:    nxt_byte = wdata_q[23:16];
      default: nxt_byte = wdata_q[31:24];
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = (ls_req && ls_wr) ? WRITE : READ;
      READ:  if (rdy_in && (flush || (!stale_q && cap_last))) state_d = IDLE;
      WRITE: if (wr_fire && last_wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      base_q   <= '0;
      wdata_q  <= '0;
      asm_q    <= '0;
      n_q      <= '0;
      idx_q    <= '0;
      vld_q    <= 1'b0;
      stale_q  <= 1'b0;
      fetch_q  <= 1'b0;
    end else if (!rdy_in) begin
      // Byte in flight is lost while paused; rewind on the first ready cycle.
      if (state_q == READ) stale_q <= 1'b1;
    end else begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            base_q  <= ls_req ? ls_addr : if_addr;
            mem_a   <= ls_req ? ls_addr : if_addr;
            n_q     <= ls_req ? size_bytes(ls_size) : 3'd4;
            fetch_q <= !ls_req;
            wdata_q <= ls_wdata;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            stale_q <= 1'b0;
            asm_q   <= '0;
            if (ls_req && ls_wr) mem_dout <= ls_wdata[7:0];
          end
        end
        READ: begin
          if (flush) begin
            stale_q <= 1'b0;
          end else if (stale_q) begin
            idx_q   <= first_idx;
            mem_a   <= base_q + ADDR_W'(first_idx);
            vld_q   <= 1'b0;
            stale_q <= 1'b0;
          end else begin
            if (vld_q) asm_q <= merged;
            if (cap_last) begin
              if (fetch_q) begin
                if_data <= merged;
                if_done <= 1'b1;
              end else begin
                ls_rdata <= merged;
                ls_done  <= 1'b1;
              end
            end else begin
              vld_q <= 1'b1;
              idx_q <= idx_nxt;
              // Never address past the last requested byte (no I/O over-read).
              if (idx_nxt < n_q) mem_a <= base_q + ADDR_W'(idx_nxt);
            end
          end
        end
        WRITE: begin
          if (wr_fire) begin
            if (last_wr) begin
              ls_done <= 1'b1;
            end else begin
              idx_q    <= idx_nxt;
              mem_a    <= base_q + ADDR_W'(idx_nxt);
              mem_dout <= nxt_byte;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a 64 KiB byte RAM (1-cycle read latency)
// and a UART sink in the 0x3xxxx window.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_wr, ls_done;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  logic [7:0]  ram [0:65535];
  int          io_writes = 0;
  logic [7:0]  io_last = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk_in = ~clk_in;

  mem_ctrl #(.ADDR_W(32), .IO_SEL(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always @(posedge clk_in) begin
    if (mem_wr) begin
      if (mem_a[17:16] == 2'b11) begin
        io_writes <= io_writes + 1;
        io_last   <= mem_dout;
      end else begin
        ram[mem_a[15:0]] <= mem_dout;
      end
    end
    mem_din <= ram[mem_a[15:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_for(input bit sel_if, input int limit, output int cyc);
    cyc = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if ((sel_if ? if_done : ls_done) === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1);
  end

  initial begin
    int c;
    logic seen;
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = SZ_B; ls_addr = '0; ls_wdata = '0;
    for (int unsigned i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'h93; ram[16'h0101] = 8'h00; ram[16'h0102] = 8'hA0; ram[16'h0103] = 8'h00;
    ram[16'h2000] = 8'h11; ram[16'h2001] = 8'h22; ram[16'h2002] = 8'h33; ram[16'h2003] = 8'h44;
    ram[16'hFFFF] = 8'hCD; ram[16'h0000] = 8'hAB;

    repeat (2) tick();
    chk("rst_if_done", 32'(if_done), 0);
    chk("rst_ls_done", 32'(ls_done), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_dout", 32'(mem_dout), 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    rst_in = 1'b0;
    tick();

    // word fetch: consecutive addresses, done in cycle 5
    if_addr = 32'h100; if_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fetch_addr", mem_a, 32'h100 + 32'(k));
      chk("fetch_no_wr", 32'(mem_wr), 0);
    end
    tick();
    chk("fetch_early", 32'(if_done), 0);
    tick();
    chk("fetch_done", 32'(if_done), 1);
    chk("fetch_data", if_data, 32'h00A00093);
    if_req = 1'b0;
    tick();
    chk("fetch_pulse", 32'(if_done), 0);

    // simultaneous fetch and lw: load first
    if_addr = 32'h100; if_req = 1'b1;
    ls_addr = 32'h2000; ls_size = SZ_W; ls_wr = 1'b0; ls_req = 1'b1;
    wait_for(1'b0, 20, c);
    chk("arb_lw_lat", 32'(c), 5);
    chk("arb_lw_data", ls_rdata, 32'h44332211);
    chk("arb_if_pending", 32'(if_done), 0);
    ls_req = 1'b0;
    wait_for(1'b1, 20, c);
    chk("arb_if_lat", 32'(c), 6);
    chk("arb_if_data", if_data, 32'h00A00093);
    if_req = 1'b0;
    tick();

    // UART store under back-pressure
    ls_addr = 32'h30000; ls_size = SZ_B; ls_wdata = 32'h41; ls_wr = 1'b1;
    io_buffer_full = 1'b1; ls_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("io_held", 32'(mem_wr), 0);
    end
    tick();
    io_buffer_full = 1'b0;
    #1;
    chk("io_wr", 32'(mem_wr), 1);
    chk("io_dout", 32'(mem_dout), 32'h41);
    tick();
    chk("io_done", 32'(ls_done), 1);
    chk("io_wr_end", 32'(mem_wr), 0);
    ls_req = 1'b0;
    chk("io_count", 32'(io_writes), 1);
    chk("io_byte", 32'(io_last), 32'h41);
    tick();

    // unaligned halfword store
    ls_addr = 32'h1003; ls_size = SZ_H; ls_wdata = 32'hBEEF; ls_wr = 1'b1; ls_req = 1'b1;
    tick();
    chk("sh_a0", mem_a, 32'h1003);
    chk("sh_d0", 32'(mem_dout), 32'hEF);
    chk("sh_w0", 32'(mem_wr), 1);
    tick();
    chk("sh_a1", mem_a, 32'h1004);
    chk("sh_d1", 32'(mem_dout), 32'hBE);
    chk("sh_w1", 32'(mem_wr), 1);
    tick();
    chk("sh_done", 32'(ls_done), 1);
    chk("sh_wr_end", 32'(mem_wr), 0);
    ls_req = 1'b0;
    chk("sh_ram0", 32'(ram[16'h1003]), 32'hEF);
    chk("sh_ram1", 32'(ram[16'h1004]), 32'hBE);
    tick();

    // fetch flushed at cycle 2, queued store proceeds
    if_addr = 32'h100; if_req = 1'b1;
    tick();
    ls_addr = 32'h1100; ls_size = SZ_B; ls_wdata = 32'h5A; ls_wr = 1'b1; ls_req = 1'b1;
    tick();
    tick();
    flush = 1'b1; if_req = 1'b0;
    tick();
    flush = 1'b0;
    chk("fl_no_done", 32'(if_done), 0);
    chk("fl_idle_wr", 32'(mem_wr), 0);
    tick();
    chk("fl_st_wr", 32'(mem_wr), 1);
    chk("fl_st_a", mem_a, 32'h1100);
    chk("fl_st_d", 32'(mem_dout), 32'h5A);
    tick();
    chk("fl_st_done", 32'(ls_done), 1);
    ls_req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (if_done) seen = 1'b1;
      tick();
    end
    chk("fl_if_never", 32'(seen), 0);
    chk("fl_ram", 32'(ram[16'h1100]), 32'h5A);

    // lw paused for 4 cycles from cycle 2
    ls_addr = 32'h2000; ls_size = SZ_W; ls_wr = 1'b0; ls_req = 1'b1;
    tick();
    tick();
    tick();
    rdy_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("pause_wr", 32'(mem_wr), 0);
      chk("pause_a", mem_a, 32'h2002);
      chk("pause_done", 32'(ls_done), 0);
      tick();
    end
    rdy_in = 1'b1;
    wait_for(1'b0, 20, c);
    chk("pause_finished", 32'(c >= 0), 1);
    chk("pause_data", ls_rdata, 32'h44332211);
    ls_req = 1'b0;
    tick();

    // halfword load wrapping the address space
    ls_addr = 32'hFFFF_FFFF; ls_size = SZ_H; ls_wr = 1'b0; ls_req = 1'b1;
    tick();
    chk("wrap_a0", mem_a, 32'hFFFF_FFFF);
    tick();
    chk("wrap_a1", mem_a, 32'h0000_0000);
    wait_for(1'b0, 20, c);
    chk("wrap_lat", 32'(c), 1);
    chk("wrap_data", ls_rdata, 32'h0000_ABCD);
    ls_req = 1'b0;
    tick();

    // byte load, zero-extended
    ls_addr = 32'h2003; ls_size = SZ_B; ls_req = 1'b1;
    wait_for(1'b0, 20, c);
    chk("lb_lat", 32'(c), 2);
    chk("lb_data", ls_rdata, 32'h0000_0044);
    ls_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
